// File: rtl/inert_cmd_seq_if.sv
// SPI command/response and sample bus between the sequencer and its neighbours.
// master = sequencer side, slave = SPI monarch / balance datapath side.
interface inert_cmd_seq_if;
    logic        wrt;
    logic [15:0] wrt_data;
    logic        done;
    logic [15:0] rd_data;
    logic [15:0] ptch_rt;
    logic [15:0] AZ;
    logic        vld;

    modport master (
        output wrt, wrt_data, ptch_rt, AZ, vld,
        input  done, rd_data
    );

    modport slave (
        input  wrt, wrt_data, ptch_rt, AZ, vld,
        output done, rd_data
    );
endinterface

// File: rtl/inert_cmd_seq.sv
// Inertial sensor command sequencer: power-up wait, four config writes, then a
// four-byte read burst per data-ready interrupt, presented as one atomic sample.
module inert_cmd_seq #(
    parameter int INIT_WAIT_BITS = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            INT,
    output logic            cfg_done,
    inert_cmd_seq_if.master bus
);
    // state    | meaning
    // WAIT_PWR | counting out sensor power-up
    // CFG      | config write in flight, step selects the command
    // IDLE     | configured, waiting for a data-ready event
    // RD       | register read in flight, step selects the byte
    // UPD      | fresh sample on ptch_rt/AZ, vld high
    typedef enum logic [2:0] {WAIT_PWR, CFG, IDLE, RD, UPD} state_t;

    state_t                    state, state_nxt;
    logic [INIT_WAIT_BITS-1:0] cnt, cnt_nxt;
    logic [1:0]                step, step_nxt;
    logic                      wrt_nxt, vld_nxt, cfg_done_nxt;
    logic [15:0]               wrt_data_nxt;
    logic                      int_s1, int_s2, int_s3, done_q;
    logic [7:0]                p_l, p_h, a_l, a_h;
    logic                      cmpl, int_evt;
    logic                      unused_rd_hi;

    assign cmpl         = bus.done & ~done_q;
    assign int_evt      = int_s2 & ~int_s3;
    assign unused_rd_hi = ^bus.rd_data[15:8];

    function automatic logic [15:0] cmd_word(input logic rd, input logic [1:0] idx);
        logic [15:0] w;
        case ({rd, idx})
            3'b000:  w = 16'h0D02;
            3'b001:  w = 16'h1053;
            3'b010:  w = 16'h1150;
            3'b011:  w = 16'h1460;
            3'b100:  w = 16'hA200;
            3'b101:  w = 16'hA300;
            3'b110:  w = 16'hAC00;
            default: w = 16'hAD00;
        endcase
        return w;
    endfunction

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        step_nxt     = step;
        wrt_nxt      = 1'b0;
        wrt_data_nxt = bus.wrt_data;
        cfg_done_nxt = cfg_done;
        vld_nxt      = 1'b0;
        case (state)
            WAIT_PWR: begin
                cnt_nxt = cnt + {{(INIT_WAIT_BITS-1){1'b0}}, 1'b1};
                if (&cnt) begin
                    state_nxt    = CFG;
                    step_nxt     = 2'd0;
                    wrt_nxt      = 1'b1;
                    wrt_data_nxt = cmd_word(1'b0, 2'd0);
                end
            end
            CFG: begin
                if (cmpl) begin
                    if (step == 2'd3) begin
                        state_nxt    = IDLE;
                        cfg_done_nxt = 1'b1;
                    end else begin
                        step_nxt     = step + 2'd1;
                        wrt_nxt      = 1'b1;
                        wrt_data_nxt = cmd_word(1'b0, step + 2'd1);
                    end
                end
            end
            IDLE: begin
                if (int_evt) begin
                    state_nxt    = RD;
                    step_nxt     = 2'd0;
                    wrt_nxt      = 1'b1;
                    wrt_data_nxt = cmd_word(1'b1, 2'd0);
                end
            end
            RD: begin
                if (cmpl) begin
                    if (step == 2'd3) begin
                        state_nxt = UPD;
                        vld_nxt   = 1'b1;
                    end else begin
                        step_nxt     = step + 2'd1;
                        wrt_nxt      = 1'b1;
                        wrt_data_nxt = cmd_word(1'b1, step + 2'd1);
                    end
                end
            end
            UPD:     state_nxt = IDLE;
            default: state_nxt = WAIT_PWR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= WAIT_PWR;
            cnt          <= '0;
            step         <= 2'd0;
            bus.wrt      <= 1'b0;
            bus.wrt_data <= 16'h0000;
            cfg_done     <= 1'b0;
            bus.vld      <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            step         <= step_nxt;
            bus.wrt      <= wrt_nxt;
            bus.wrt_data <= wrt_data_nxt;
            cfg_done     <= cfg_done_nxt;
            bus.vld      <= vld_nxt;
        end
    end

    // Last byte goes straight to the output so the sample and vld land in UPD together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            int_s1      <= 1'b0;
            int_s2      <= 1'b0;
            int_s3      <= 1'b0;
            done_q      <= 1'b0;
            p_l         <= 8'h00;
            p_h         <= 8'h00;
            a_l         <= 8'h00;
            a_h         <= 8'h00;
            bus.ptch_rt <= 16'h0000;
            bus.AZ      <= 16'h0000;
        end else begin
            int_s1 <= INT;
            int_s2 <= int_s1;
            int_s3 <= int_s2;
            done_q <= bus.done;
            if (state == RD && cmpl) begin
                case (step)
                    2'd0:    p_l <= bus.rd_data[7:0];
                    2'd1:    p_h <= bus.rd_data[7:0];
                    2'd2:    a_l <= bus.rd_data[7:0];
                    default: begin
                        a_h         <= bus.rd_data[7:0];
                        bus.ptch_rt <= {p_h, p_l};
                        bus.AZ      <= {bus.rd_data[7:0], a_l};
                    end
                endcase
            end
        end
    end
endmodule

// File: doc/inert_cmd_seq.md
# inert_cmd_seq

Command sequencer that sits directly upstream of the SPI monarch and drives it to talk to the inertial sensor. After reset it waits for sensor power-up, issues four configuration writes, then on every data-ready interrupt reads pitch rate and Z acceleration as byte pairs. It presents them as synchronized 16-bit samples with a one-cycle valid strobe to the balance-control datapath.

## Interface
- `INIT_WAIT_BITS`, default 16: width of the power-up wait counter. The wait is 2^INIT_WAIT_BITS − 1 clocks. Benches use 4.
- `clk` in 1: 50 MHz system clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `INT` in 1: sensor data-ready interrupt, asynchronous, active-high.
- `done` in 1: SPI transaction complete, a level from the SPI monarch.
- `rd_data` in 16: SPI read data; bits [7:0] carry the register byte.
- `wrt` out 1: one-cycle pulse that starts an SPI transaction.
- `wrt_data` out 16: SPI command word.
- `cfg_done` out 1: high once configuration has finished; stays high until reset.
- `ptch_rt` out 16: signed pitch rate, {high byte, low byte}.
- `AZ` out 16: signed Z acceleration, {high byte, low byte}.
- `vld` out 1: one-cycle strobe; `ptch_rt` and `AZ` have just been updated together.

## Operation
- **INT synchronizer.** INT passes through two flops. A start event is a rising edge of the second flop, detected against a third registered copy.
- **Completion detect.** Completion is a rising edge of `done`: `done` is high and the registered `done` from the prior cycle is low. Stale-high `done` left over from a previous transaction is never treated as completion.
- **Issuing a transaction.** Each transaction has two parts:
  - Asserting cycle: `wrt`=1 for exactly one cycle, with `wrt_data` valid in the same cycle.
  - Waiting: `wrt_data` is held unchanged until completion is detected. `wrt` stays 0 while waiting.
- **State machine** (next-state logic plus registered state):
  - WAIT_PWR: counter increments each clock. When it reaches all-ones, go to CFG.
  - CFG: issue the commands in order, each waiting for completion: 0x0D02 (INT on data-ready), 0x1053 (accel 208 Hz), 0x1150 (gyro 208 Hz), 0x1460 (rounding). After the 4th completion, set `cfg_done` and go to IDLE.
  - IDLE: on an INT start event, go to RD.
  - RD: issue reads in order, each waiting for completion:
    - 0xA200 (pitch low): capture `rd_data[7:0]` into staging P_L.
    - 0xA300 (pitch high): capture into P_H.
    - 0xAC00 (AZ low): capture into A_L.
    - 0xAD00 (AZ high): capture into A_H.
  - After the 4th completion, go to UPD.
  - UPD (1 cycle): `ptch_rt`←{P_H,P_L}, `AZ`←{A_H,A_L}, `vld`=1, return to IDLE.
- **Step counting.** A 2-bit step counter selects the command within CFG and within RD. It is cleared on entry to either state and incremented on each completion.
- **INT handling outside IDLE.** INT start events in WAIT_PWR, CFG, RD or UPD are dropped. They are not queued.
- **Output stability.** `ptch_rt` and `AZ` change only in UPD; no partial sample is ever visible.

## Timing
- **Reset values:**
  - state WAIT_PWR, counter 0, step 0;
  - `wrt`=0, `wrt_data`=0x0000, `cfg_done`=0, `vld`=0;
  - `ptch_rt`=0, `AZ`=0, staging registers 0, synchronizer flops 0.
- **Reset mid-operation.** `rst_n` low at any clock edge forces all reset values at that edge, including mid-transaction. No further `wrt` is issued until the power-up wait completes again.
- **Power-up wait to first command.** The first `wrt` is asserted 2^INIT_WAIT_BITS clocks after the first edge with `rst_n` high. With `INIT_WAIT_BITS`=4, `wrt` is high at cycle 16.
- **Back-to-back commands.** The next `wrt` is asserted in the cycle after completion is detected, so there is 1 idle cycle between the `done` edge and the next `wrt`.
- **INT to first read.** External INT rise → second sync flop high after 2 edges → start event → `wrt` for 0xA200 asserted on the following cycle.
- **Last completion to valid.** `vld` is high in the cycle after the AZ-high completion cycle.
- **Simultaneous events.**
  - An INT start event in the same cycle as the 4th CFG completion is dropped.
  - An INT start event in the UPD cycle is dropped.
- **Sign.** Bytes are concatenated without sign extension; bit 15 is the sign bit.

## Test plan
- **Power-up and configuration.** `INIT_WAIT_BITS`=4; SPI model raises `done` 20 cycles after each `wrt`.
  - `wrt` pulses at cycle 16 with `wrt_data` 0x0D02, followed by 0x1053, 0x1150, 0x1460.
  - `cfg_done` rises after the 4th `done` edge.
  - No `wrt` at any time before cycle 16.
- **Read sequence.** After configuration, pulse INT; model returns low bytes 0x34, 0x12, 0xF0, 0xFF in order.
  - Commands are 0xA200, 0xA300, 0xAC00, 0xAD00.
  - `vld` is a single cycle with `ptch_rt`=0x1234 and `AZ`=0xFFF0.
- **Stale done.** Hold `done` high between transactions.
  - The next command waits for a true low→high edge.
  - `wrt_data` stays stable throughout, and exactly one `wrt` pulse is issued per command.
- **Dropped interrupts.** Raise INT during the third read, then again in the UPD cycle.
  - Exactly one `vld` results.
  - A later INT pulse produces a new 4-read sequence.
- **Reset mid-read.** Drop `rst_n` low for 1 cycle during the 0xA300 read.
  - All outputs return to reset values; `ptch_rt` stays 0.
  - The power-up wait and all 4 configuration writes repeat before any read.
- **Output atomicity.** Two INT samples, with the first returning 0x01,0x00,0x02,0x00 and the second 0xFF,0x7F,0x00,0x80.
  - `ptch_rt`/`AZ` go from 0x0001/0x0002 to 0x7FFF/0x8000.
  - They change only in the `vld` cycles.
